// File: rtl/adder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder_pkg: opcodes, flag bit positions and decode for adder64.    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package adder_pkg;

    localparam int c_LANE_W = 32;

    typedef enum logic [2:0] {
        OP_ADD64       = 3'd0,
        OP_SUB64       = 3'd1,
        OP_ADD2X32     = 3'd2,
        OP_SUB2X32     = 3'd3,
        OP_ADDLO_SUBHI = 3'd4,
        OP_SUBLO_ADDHI = 3'd5
    } op_e;

    localparam int c_F_HI_Z = 7;
    localparam int c_F_HI_N = 6;
    localparam int c_F_HI_C = 5;
    localparam int c_F_HI_V = 4;
    localparam int c_F_LO_Z = 3;
    localparam int c_F_LO_N = 2;
    localparam int c_F_LO_C = 1;
    localparam int c_F_LO_V = 0;

    typedef struct packed {
        logic ill;
        logic mode;
        logic sub_uni;
        logic sub_lo;
        logic sub_hi;
    } ctrl_t;

    // Illegal opcodes leave every adder control low and only raise ill.
    function automatic ctrl_t decode_op(input logic [2:0] op);
        ctrl_t d;
        d = '0;
        case (op)
            OP_ADD64:       d.mode = 1'b1;
            OP_SUB64:       begin d.mode = 1'b1; d.sub_uni = 1'b1; end
            OP_ADD2X32:     d.mode = 1'b0;
            OP_SUB2X32:     begin d.sub_lo = 1'b1; d.sub_hi = 1'b1; end
            OP_ADDLO_SUBHI: d.sub_hi = 1'b1;
            OP_SUBLO_ADDHI: d.sub_lo = 1'b1;
            default:        d.ill = 1'b1;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_lane_flags.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder_lane_flags: Z/N/C/V for one 32-bit adder lane.              |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module adder_lane_flags
    import adder_pkg::*;
(
    input  logic [c_LANE_W-1:0] i_a,
    input  logic [c_LANE_W-1:0] i_b,
    input  logic [c_LANE_W-1:0] i_sum,
    input  logic                i_is_sub,
    input  logic                i_c_ovr_en,
    input  logic                i_c_ovr,
    output logic                o_z,
    output logic                o_n,
    output logic                o_c,
    output logic                o_v
);

    logic w_sa;
    logic w_sb;
    logic w_sr;

    assign w_sa = i_a[c_LANE_W-1];
    assign w_sb = i_b[c_LANE_W-1];
    assign w_sr = i_sum[c_LANE_W-1];

    assign o_z = (i_sum == '0);
    assign o_n = w_sr;
    // Subtract reports no-borrow; add reports lane carry-out unless overridden.
    assign o_c = i_c_ovr_en ? i_c_ovr
               : (i_is_sub ? (i_a >= i_b) : (i_sum < i_a));
    assign o_v = i_is_sub ? ((w_sa != w_sb) && (w_sr != w_sa))
                          : ((w_sa == w_sb) && (w_sr != w_sa));

endmodule
`default_nettype wire

// File: rtl/adder64_pipe_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder64_pipe_ctrl: two-stage valid/ready control around adder64.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module adder64_pipe_ctrl
    import adder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    output logic [63:0]      add_a,
    output logic [63:0]      add_b,
    output logic             add_mode,
    output logic             add_sub_uni,
    output logic             add_sub_lo,
    output logic             add_sub_hi,
    input  logic [63:0]      add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sum,
    output logic [7:0]       out_flags,
    output logic             out_err,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] ill_cnt
);

    ctrl_t             w_dec;
    ctrl_t             r_ctrl;
    logic [63:0]       r_a;
    logic [63:0]       r_b;
    logic              r_s1_vld;
    logic              r_s2_vld;
    logic [63:0]       r_sum;
    logic [7:0]        r_flags;
    logic              r_err;
    logic [CNT_W-1:0]  r_op_cnt;
    logic [CNT_W-1:0]  r_ill_cnt;
    logic              w_s1_adv;
    logic              w_acc;
    logic              w_s1_xfer;
    logic              w_deliver;
    logic              w_hi_sub;
    logic              w_uni_c;
    logic              w_lo_z, w_lo_n, w_lo_c, w_lo_v;
    logic              w_hi_z, w_hi_n, w_hi_c, w_hi_v;
    logic [7:0]        w_flags;

    assign w_dec     = decode_op(in_op);
    assign w_s1_adv  = !r_s2_vld || out_ready;
    assign in_ready  = rst_n && !flush && (!r_s1_vld || w_s1_adv);
    assign w_acc     = in_valid && in_ready;
    assign w_s1_xfer = r_s1_vld && w_s1_adv;
    assign w_deliver = r_s2_vld && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_ctrl   <= '0;
        end else begin
            if (flush)          r_s1_vld <= 1'b0;
            else if (w_acc)     r_s1_vld <= 1'b1;
            else if (w_s1_xfer) r_s1_vld <= 1'b0;
            if (w_acc) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_ctrl <= w_dec;
            end
        end
    end

    assign add_a       = r_a;
    assign add_b       = r_b;
    assign add_mode    = r_ctrl.mode;
    assign add_sub_uni = r_ctrl.sub_uni;
    assign add_sub_lo  = r_ctrl.sub_lo;
    assign add_sub_hi  = r_ctrl.sub_hi;

    // In unified mode the hi lane's carry stands for the full 64-bit operation.
    assign w_hi_sub = r_ctrl.mode ? r_ctrl.sub_uni : r_ctrl.sub_hi;
    assign w_uni_c  = r_ctrl.sub_uni ? (r_a >= r_b) : add_cout;

    adder_lane_flags u_lo_flags (
        .i_a        (r_a[31:0]),
        .i_b        (r_b[31:0]),
        .i_sum      (add_sum[31:0]),
        .i_is_sub   (r_ctrl.sub_lo),
        .i_c_ovr_en (1'b0),
        .i_c_ovr    (1'b0),
        .o_z        (w_lo_z),
        .o_n        (w_lo_n),
        .o_c        (w_lo_c),
        .o_v        (w_lo_v)
    );

    adder_lane_flags u_hi_flags (
        .i_a        (r_a[63:32]),
        .i_b        (r_b[63:32]),
        .i_sum      (add_sum[63:32]),
        .i_is_sub   (w_hi_sub),
        .i_c_ovr_en (r_ctrl.mode),
        .i_c_ovr    (w_uni_c),
        .o_z        (w_hi_z),
        .o_n        (w_hi_n),
        .o_c        (w_hi_c),
        .o_v        (w_hi_v)
    );

    always_comb begin
        w_flags = '0;
        if (!r_ctrl.ill) begin
            w_flags[c_F_HI_Z] = w_hi_z && (!r_ctrl.mode || (add_sum[31:0] == '0));
            w_flags[c_F_HI_N] = w_hi_n;
            w_flags[c_F_HI_C] = w_hi_c;
            w_flags[c_F_HI_V] = w_hi_v;
            if (!r_ctrl.mode) begin
                w_flags[c_F_LO_Z] = w_lo_z;
                w_flags[c_F_LO_N] = w_lo_n;
                w_flags[c_F_LO_C] = w_lo_c;
                w_flags[c_F_LO_V] = w_lo_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_sum     <= '0;
            r_flags   <= '0;
            r_err     <= 1'b0;
            r_op_cnt  <= '0;
            r_ill_cnt <= '0;
        end else begin
            if (flush) begin
                r_s2_vld <= 1'b0;
            end else if (w_s1_xfer) begin
                r_s2_vld <= 1'b1;
                r_sum    <= r_ctrl.ill ? 64'd0 : add_sum;
                r_flags  <= w_flags;
                r_err    <= r_ctrl.ill;
            end else if (w_deliver) begin
                r_s2_vld <= 1'b0;
            end
            if (w_deliver && (r_op_cnt != '1))
                r_op_cnt <= r_op_cnt + 1'b1;
            if (w_deliver && r_err && (r_ill_cnt != '1))
                r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    assign out_valid = r_s2_vld;
    assign out_sum   = r_sum;
    assign out_flags = r_flags;
    assign out_err   = r_err;
    assign op_cnt    = r_op_cnt;
    assign ill_cnt   = r_ill_cnt;

endmodule
`default_nettype wire
